lcd1602_ctrlmod: RTL
====================

# lcd1602_ctrlmod

Sequencer for the LCD1602 byte-write function module. It runs the power-on delay and the HD44780 init command sequence. It then owns a 32-byte character buffer that the host writes, and refreshes both display lines through the byte-writer whenever the buffer changes. It sits between application logic and the byte-writer, which carries RS/DATA per transaction.

## Interface
- PWR_DELAY, 1_000_000 — cycles waited after reset before the first command (20 ms @ 50 MHz).
- CLR_WAIT, 100_000 — extra cycles waited after the clear-display command completes (2 ms).
- CLOCK  in  1  system clock, rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- iWrEn  in  1  host buffer write strobe, one byte per cycle.
- iWrAddr  in  5  buffer address; 0–15 = line 1 cols 0–15, 16–31 = line 2.
- iWrData  in  8  character code.
- oBusy  out  1  high whenever the FSM is not in IDLE.
- oCall  out  1  request to byte-writer; held until iDone.
- oRS  out  1  0 = instruction, 1 = data; valid while oCall high.
- oDATA  out  8  byte to write; valid while oCall high.
- iDone  in  1  one-cycle completion pulse from byte-writer.

## Operation
- Reset values:
  - oCall=0, oRS=0, oDATA=0x00, oBusy=1.
  - FSM=PWR_WAIT, delay counter=0, dirty=1.
  - All 32 buffer bytes = 0x20 (space).
- FSM states: PWR_WAIT → INIT (4 cmds) → CLR_HOLD → IDLE ⇄ REFRESH (ADDR1, LINE1, ADDR2, LINE2).
  - PWR_WAIT: count to PWR_DELAY-1, then go to INIT.
  - INIT: issue instructions 0x38, 0x0C, 0x06, 0x01 in order, each as one transaction. After 0x01 completes, go to CLR_HOLD.
  - CLR_HOLD: count to CLR_WAIT-1, then go to IDLE.
  - IDLE: oBusy=0. If dirty, clear dirty and enter ADDR1.
  - ADDR1: instruction 0x80. LINE1: data buf[0..15]. ADDR2: instruction 0xC0. LINE2: data buf[16..31]. Then return to IDLE.
- Transaction rule:
  - Assert oCall with oRS/oDATA stable.
  - On the cycle iDone=1 is sampled, deassert oCall in the next cycle.
  - Keep oCall low for at least one full cycle before the next request.
  - iDone while oCall=0 is ignored.
- The buffer byte is sampled into oDATA in the cycle oCall rises. Later writes to that address do not alter an in-flight transaction.
- Host writes are accepted in every state, including during init and refresh.
  - Any write sets dirty.
  - A write in the same cycle that IDLE clears dirty leaves dirty=1 (set wins). A write during refresh therefore triggers one more full refresh.
- Column counter is 4 bits and wraps 15→0 on the LINE1→ADDR2 and LINE2→IDLE transitions.
- Delay counters are 20 bits and reset to 0 on every state exit.
- RST_n low mid-transaction: oCall drops asynchronously. The sequence restarts from PWR_WAIT with the buffer refilled with spaces.

## Timing
- First oCall rises PWR_DELAY+1 cycles after reset release.
- Per transaction overhead: 1 cycle (oCall rise) + byte-writer latency + 1 cycle deassert + 1 idle gap.
- A full refresh is 34 transactions: 2 address instructions + 32 data bytes.
- oBusy falls the cycle IDLE is entered. It rises the cycle after dirty is observed in IDLE.
- The write port has zero-latency effect on the buffer: a byte written in cycle N is readable for a transaction starting in cycle N+1.

## Structure
- Shared package lcd1602_pkg:
  - Instruction constants: FUNC_SET=0x38, DISP_ON=0x0C, ENTRY_MODE=0x06, CLEAR=0x01, LINE1_ADDR=0x80, LINE2_ADDR=0xC0.
  - FSM state enum.
  - Timing defaults shared with the byte-writer.
- One sub-module, lcd1602_bufmod: 32×8 register file with 1 write port, 1 async read port and reset-to-0x20.

## Test plan
- Run with PWR_DELAY=1000 and CLR_WAIT=100, and a byte-writer model that returns iDone 5 cycles after oCall.
- Reset → the first four transactions are RS=0 with bytes 0x38, 0x0C, 0x06, 0x01. The first oCall rises at cycle 1001. oBusy stays 1 until CLR_HOLD ends.
- After init with the untouched buffer → one refresh: 0x80, then 16×0x20, then 0xC0, then 16×0x20. oBusy then goes low and no further calls occur.
- Write "HELLO" at addresses 0–4 and 'A' (0x41) at address 31 while IDLE → refresh LINE1 data 48 45 4C 4C 4F then 11×20, and the last LINE2 byte is 0x41.
- Write 0x5A to address 20 while LINE1 is in progress → the current refresh shows 0x5A in its LINE2 (not yet sampled). A second full refresh follows, and then the FSM goes IDLE.
- Write coincident with the IDLE dirty-clear cycle → two back-to-back refreshes. Check that oCall is low for ≥1 cycle between every pair of transactions.
- Assert RST_n for 3 cycles mid-LINE2 with oCall high → oCall is 0 during reset. After release the controller waits 1000 cycles and replays 0x38 first, and the buffer reads all 0x20.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared constants for the LCD1602 controller and byte-writer: instruction codes,
// FSM state encodings, buffer geometry and default timing.
package lcd1602_pkg;

  localparam int DEF_PWR_DELAY = 1_000_000;
  localparam int DEF_CLR_WAIT  = 100_000;
  localparam int CNT_W         = 20;

  localparam int BUF_DEPTH = 32;
  localparam int BUF_AW    = 5;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  typedef logic [2:0] lcdState_t;

  localparam lcdState_t PWR_WAIT = 3'd0;
  localparam lcdState_t INIT     = 3'd1;
  localparam lcdState_t CLR_HOLD = 3'd2;
  localparam lcdState_t IDLE     = 3'd3;
  localparam lcdState_t ADDR1    = 3'd4;
  localparam lcdState_t LINE1    = 3'd5;
  localparam lcdState_t ADDR2    = 3'd6;
  localparam lcdState_t LINE2    = 3'd7;

  function automatic logic [7:0] initCmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = FUNC_SET;
      2'd1:    cmd = DISP_ON;
      2'd2:    cmd = ENTRY_MODE;
      default: cmd = CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd1602_bufmod.sv
// 32x8 character buffer: one write port, one combinational read port,
// every cell returns to a space on reset.
module lcd1602_bufmod
  import lcd1602_pkg::*;
(
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic              wrEn,
  input  logic [BUF_AW-1:0] wrAddr,
  input  logic [7:0]        wrData,
  input  logic [BUF_AW-1:0] rdAddr,
  output logic [7:0]        rdData
);

  logic [BUF_DEPTH-1:0][7:0] cellVal;

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : gCell
      logic [7:0] cellReg;

      always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
          cellReg <= SPACE_CHAR;
        end else if (wrEn && (wrAddr == BUF_AW'(gi))) begin
          cellReg <= wrData;
        end
      end

      assign cellVal[gi] = cellReg;
    end
  endgenerate

  assign rdData = cellVal[rdAddr];

endmodule

// File: rtl/lcd1602_ctrlmod.sv
// LCD1602 sequencer: power-on wait, HD44780 init, then full two-line refreshes
// of the character buffer through the byte-writer whenever the host changes it.
module lcd1602_ctrlmod
  import lcd1602_pkg::*;
#(
  parameter int PWR_DELAY = DEF_PWR_DELAY,
  parameter int CLR_WAIT  = DEF_CLR_WAIT
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       iWrEn,
  input  logic [4:0] iWrAddr,
  input  logic [7:0] iWrData,
  output logic       oBusy,
  output logic       oCall,
  output logic       oRS,
  output logic [7:0] oDATA,
  input  logic       iDone
);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DELAY - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT - 1);

  lcdState_t        stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [1:0]       stepReg, stepNext;
  logic [3:0]       colReg, colNext;
  logic             dirtyReg;
  logic             callReg;
  logic             gapReg;
  logic             rsReg;
  logic [7:0]       dataReg;

  logic             isTxn;
  logic             txnRs;
  logic [7:0]       txnByte;
  logic             txnDone;
  logic [4:0]       rdAddr;
  logic [7:0]       rdData;

  lcd1602_bufmod uBuf (
    .CLOCK  (CLOCK),
    .RST_n  (RST_n),
    .wrEn   (iWrEn),
    .wrAddr (iWrAddr),
    .wrData (iWrData),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  assign rdAddr  = {stateReg == LINE2, colReg};
  assign txnDone = callReg && iDone;

  // What the current state wants to send; only sampled on the cycle oCall rises.
  always_comb begin
    isTxn   = 1'b0;
    txnRs   = 1'b0;
    txnByte = 8'h00;
    case (stateReg)
      INIT: begin
        isTxn   = 1'b1;
        txnByte = initCmd(stepReg);
      end
      ADDR1: begin
        isTxn   = 1'b1;
        txnByte = LINE1_ADDR;
      end
      ADDR2: begin
        isTxn   = 1'b1;
        txnByte = LINE2_ADDR;
      end
      LINE1, LINE2: begin
        isTxn   = 1'b1;
        txnRs   = 1'b1;
        txnByte = rdData;
      end
      default: ;
    endcase
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    stepNext  = stepReg;
    colNext   = colReg;
    case (stateReg)
      PWR_WAIT: begin
        if (cntReg == PWR_LAST) begin
          stateNext = INIT;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      INIT: begin
        if (txnDone) begin
          stepNext = stepReg + 2'd1;
          if (stepReg == 2'd3) stateNext = CLR_HOLD;
        end
      end
      CLR_HOLD: begin
        if (cntReg == CLR_LAST) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      IDLE: begin
        if (dirtyReg) stateNext = ADDR1;
      end
      ADDR1: begin
        if (txnDone) begin
          stateNext = LINE1;
          colNext   = 4'd0;
        end
      end
      LINE1: begin
        if (txnDone) begin
          colNext = colReg + 4'd1;
          if (colReg == 4'hF) stateNext = ADDR2;
        end
      end
      ADDR2: begin
        if (txnDone) stateNext = LINE2;
      end
      LINE2: begin
        if (txnDone) begin
          colNext = colReg + 4'd1;
          if (colReg == 4'hF) stateNext = IDLE;
        end
      end
      default: begin
        stateNext = PWR_WAIT;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      stateReg <= PWR_WAIT;
      cntReg   <= '0;
      stepReg  <= 2'd0;
      colReg   <= 4'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      stepReg  <= stepNext;
      colReg   <= colNext;
    end
  end

  // A host write beats the IDLE clear, so a change mid-refresh always earns another pass.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      dirtyReg <= 1'b1;
    end else if (iWrEn) begin
      dirtyReg <= 1'b1;
    end else if (stateReg == IDLE) begin
      dirtyReg <= 1'b0;
    end
  end

  // Request handshake: drop after iDone, then one forced idle cycle before the next rise.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      callReg <= 1'b0;
      gapReg  <= 1'b0;
      rsReg   <= 1'b0;
      dataReg <= 8'h00;
    end else if (txnDone) begin
      callReg <= 1'b0;
      gapReg  <= 1'b1;
    end else if (gapReg) begin
      gapReg <= 1'b0;
    end else if (isTxn && !callReg) begin
      callReg <= 1'b1;
      rsReg   <= txnRs;
      dataReg <= txnByte;
    end
  end

  assign oBusy = (stateReg != IDLE);
  assign oCall = callReg;
  assign oRS   = rsReg;
  assign oDATA = dataReg;

endmodule
